tdc_capture_ctrl: RTL and testbench

TDC_CAPTURE_CTRL -- requirements
Module: tdc_capture_ctrl

---
 rtl/tdc_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_tdc_capture_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_capture_ctrl
//
// Sequences one capture+readout of an external TDC capture buffer:
//   IDLE  -> waits for start, latches the effective readout length
//   ARM   -> holds cap_en high for ARM_CYCLES cycles (rising edge = capture)
//   WAIT  -> waits CAP_CYCLES cycles so the buffer finishes its capture window
//   READ  -> walks rd_addr from 0 and streams samples out with valid/ready
//   FLUSH -> holds the final beat until the sink accepts it, then pulses done
// abort in any non-IDLE state returns to IDLE next cycle with an aborted pulse.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : request one capture+readout (sampled in IDLE only)
//   abort      : terminate current operation (ignored in IDLE)
//   cfg_len    : samples to read; 0 or > DEPTH means DEPTH
//   cap_en     : enable to the capture buffer
//   rd_addr    : read address to the capture buffer
//   rd_data    : buffer read data, combinational from rd_addr
//   out_data   : stream sample
//   out_valid  : stream valid
//   out_ready  : stream ready
//   out_last   : marks the final beat
//   busy       : high in any state other than IDLE
//   done       : one-cycle pulse on normal completion
//   aborted    : one-cycle pulse when abort takes effect
// -----------------------------------------------------------------------------
module tdc_capture_ctrl #(
   parameter int DEPTH      = 500,  // buffer depth, must fit the 9-bit address
   parameter int ARM_CYCLES = 2,
   parameter int CAP_CYCLES = 504
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [8:0] cfg_len,
   output logic       cap_en,
   output logic [8:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       done,
   output logic       aborted
);

   // ---------------------------------------------------------------------------
   // State encoding and derived constants
   // ---------------------------------------------------------------------------
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARM   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_FLUSH = 3'd4;

   // One shared counter serves ARM and WAIT; size it for the longer phase.
   localparam int CNT_MAX = (ARM_CYCLES > CAP_CYCLES) ? ARM_CYCLES : CAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYCLES - 1);
   localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_CYCLES - 1);
   localparam logic [8:0]       DEPTH_LEN  = 9'(DEPTH);
   localparam logic [8:0]       DEPTH_LAST = 9'(DEPTH - 1);

   // ---------------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------------
   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [8:0]       last_addr;   // effective length - 1, latched on start

   // Next-state values
   logic [2:0]       state_n;
   logic [CNT_W-1:0] cnt_n;
   logic [8:0]       last_addr_n;
   logic [8:0]       rd_addr_n;
   logic [7:0]       out_data_n;
   logic             out_valid_n;
   logic             out_last_n;
   logic             cap_en_n;
   logic             done_n;
   logic             aborted_n;

   // Helpers
   logic [8:0]       eff_last;    // effective length - 1 from cfg_len
   logic             at_last;     // rd_addr points at the final sample
   logic             can_load;    // output register is free this cycle

   // ---------------------------------------------------------------------------
   // Effective length: zero or oversize requests read the whole buffer.
   // Storing length-1 lets the READ logic compare rd_addr directly.
   // ---------------------------------------------------------------------------
   always_comb begin
      if ((cfg_len == 9'd0) || (cfg_len > DEPTH_LEN)) begin
         eff_last = DEPTH_LAST;
      end else begin
         eff_last = cfg_len - 9'd1;
      end
   end

   assign at_last  = (rd_addr == last_addr);
   // The output register can take a new sample when it is empty or its
   // current beat is being accepted in this same cycle.
   assign can_load = !out_valid || out_ready;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path leaves it unassigned; an unassigned path would infer a latch.
      state_n     = state;
      cnt_n       = cnt;
      last_addr_n = last_addr;
      rd_addr_n   = rd_addr;
      out_data_n  = out_data;
      out_valid_n = out_valid;
      out_last_n  = out_last;
      cap_en_n    = 1'b0;
      done_n      = 1'b0;
      aborted_n   = 1'b0;

      case (state)
         S_IDLE: begin
            // start together with abort is treated as no request at all
            if (start && !abort) begin
               state_n     = S_ARM;
               cnt_n       = '0;
               last_addr_n = eff_last;
               rd_addr_n   = 9'd0;
               cap_en_n    = 1'b1;
            end
         end

         S_ARM: begin
            // cap_en is registered, so it is raised on the IDLE->ARM edge and
            // kept up until the edge that leaves ARM: ARM_CYCLES cycles high.
            if (cnt == ARM_LAST) begin
               state_n = S_WAIT;
               cnt_n   = '0;
            end else begin
               cnt_n    = cnt + 1'b1;
               cap_en_n = 1'b1;
            end
         end

         S_WAIT: begin
            if (cnt == CAP_LAST) begin
               state_n   = S_READ;
               cnt_n     = '0;
               rd_addr_n = 9'd0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         S_READ: begin
            if (can_load) begin
               out_data_n  = rd_data;
               out_valid_n = 1'b1;
               out_last_n  = at_last;
               // Stop the address at the final sample instead of stepping
               // past it; FLUSH then drains the last beat.
               if (at_last) begin
                  state_n = S_FLUSH;
               end else begin
                  rd_addr_n = rd_addr + 9'd1;
               end
            end
         end

         S_FLUSH: begin
            // out_valid is always 1 here; wait for the sink to take it.
            if (out_ready) begin
               state_n     = S_IDLE;
               out_valid_n = 1'b0;
               out_last_n  = 1'b0;
               done_n      = 1'b1;
            end
         end

         default: begin
            state_n     = S_IDLE;
            cnt_n       = '0;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
         end
      endcase

      // Abort overrides every other transition, including FLUSH completion,
      // so done and aborted can never pulse together.
      if (abort && (state != S_IDLE)) begin
         state_n     = S_IDLE;
         cnt_n       = '0;
         rd_addr_n   = 9'd0;
         cap_en_n    = 1'b0;
         out_valid_n = 1'b0;
         out_last_n  = 1'b0;
         done_n      = 1'b0;
         aborted_n   = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         last_addr <= 9'd0;
         rd_addr   <= 9'd0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         cap_en    <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // computed from the previous cycle, independent of statement order.
         state     <= state_n;
         cnt       <= cnt_n;
         last_addr <= last_addr_n;
         rd_addr   <= rd_addr_n;
         out_data  <= out_data_n;
         out_valid <= out_valid_n;
         out_last  <= out_last_n;
         cap_en    <= cap_en_n;
         done      <= done_n;
         aborted   <= aborted_n;
      end
   end

   // Decoded straight from the state register, so reset clears it at once.
   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_capture_ctrl
//
// Self-checking bench for tdc_capture_ctrl. The capture buffer is modelled as
// an array of random bytes read combinationally. Each run derives its
// expectations from the transaction rules: the effective length, the expected
// byte sequence mem[0..L-1], the final-beat marker and the end-to-end latency
// ARM_CYCLES + CAP_CYCLES + L + 2.
// -----------------------------------------------------------------------------
module tb_tdc_capture_ctrl;

   localparam int DEPTH      = 500;
   localparam int ARM_CYCLES = 2;
   localparam int CAP_CYCLES = 504;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [8:0] cfg_len = 9'd0;
   logic       cap_en;
   logic [8:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       aborted;

   logic [7:0] mem [512];
   int total = 0;
   int bad   = 0;

   assign rd_data = mem[rd_addr];

   always #5 clk = ~clk;

   tdc_capture_ctrl #(
      .DEPTH      (DEPTH),
      .ARM_CYCLES (ARM_CYCLES),
      .CAP_CYCLES (CAP_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .cfg_len   (cfg_len),
      .cap_en    (cap_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One start request followed by observation until done, abort or reset.
   //   rmode       : 0 ready high, 1 ready toggling 1010..., 2 ready random
   //   abort_beats : abort once this many beats have transferred (-1 = never)
   //   abort_cyc   : abort at this cycle after start (-1 = never)
   //   start_cyc   : pulse an extra start at this cycle (-1 = never)
   //   rst_cyc     : assert reset between edges at this cycle (-1 = never)
   task automatic run(input logic [8:0] cfg, input int rmode, input int abort_beats,
                      input int abort_cyc, input int start_cyc, input int rst_cyc);
      int L, n, beats, done_at, first_at, cap_hi, cap_rise, abort_cnt, viol, budget;
      logic prev_cap, pv, pr, rdy, tog, fin, ab_pend, early, pl;
      logic [7:0] pd;
      logic [8:0] pa;

      L = ((cfg == 9'd0) || (int'(cfg) > DEPTH)) ? DEPTH : int'(cfg);
      n = 0; beats = 0; done_at = 0; first_at = 0; cap_hi = 0; cap_rise = 0;
      abort_cnt = 0; viol = 0;
      prev_cap = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'd0; pa = 9'd0;
      rdy = 1'b0; tog = 1'b1; fin = 1'b0; ab_pend = 1'b0; early = 1'b0;
      budget = ARM_CYCLES + CAP_CYCLES + 4 * L + 50;

      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);

      cfg_len   = cfg;
      start     = 1'b1;
      abort     = 1'b0;
      out_ready = 1'b0;

      while (!fin && (n < budget)) begin
         @(posedge clk);
         #1;
         n++;
         start = 1'b0;
         abort = 1'b0;
         if (ab_pend) begin
            check("abort_busy", busy, 0);
            check("abort_valid", out_valid, 0);
            check("abort_last", out_last, 0);
            check("abort_pulse", aborted, 1);
            check("abort_no_done", done, 0);
            check("abort_cap_en", cap_en, 0);
            @(posedge clk);
            #1;
            check("abort_pulse_width", aborted, 0);
            check("abort_stays_idle", busy, 0);
            fin   = 1'b1;
            early = 1'b1;
         end else if (n == rst_cyc) begin
            check("rst_pre_busy", busy, 1);
            rst = 1'b1;
            #1;
            check("rst_async_outputs",
                  {cap_en, rd_addr, out_data, out_valid, out_last, busy, done, aborted}, 0);
            rst = 1'b0;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk);
               #1;
               check("rst_after_busy", busy, 0);
               check("rst_after_pulses", {done, aborted}, 0);
            end
            fin   = 1'b1;
            early = 1'b1;
         end else begin
            if (cap_en) cap_hi++;
            if (cap_en && !prev_cap) cap_rise++;
            prev_cap = cap_en;
            if (busy && (int'(rd_addr) > L - 1)) viol++;
            if (pv && !pr) begin
               check("stall_data", out_data, pd);
               check("stall_last", out_last, pl);
               check("stall_addr", rd_addr, pa);
            end
            if (out_valid && (first_at == 0)) first_at = n;
            if (aborted) abort_cnt++;
            if (done) begin
               done_at = n;
               check("done_valid_low", out_valid, 0);
               fin = 1'b1;
            end else begin
               if (n == start_cyc) begin
                  start   = 1'b1;
                  cfg_len = 9'd3;
               end
               if ((n == abort_cyc) || ((abort_beats >= 0) && (beats == abort_beats))) begin
                  abort     = 1'b1;
                  rdy       = 1'b0;
                  out_ready = 1'b0;
                  ab_pend   = 1'b1;
               end else begin
                  case (rmode)
                     0:       rdy = 1'b1;
                     1:       begin rdy = tog; tog = !tog; end
                     default: rdy = 1'($urandom_range(0, 1));
                  endcase
                  out_ready = rdy;
                  if (out_valid && rdy) begin
                     check("beat_data", out_data, mem[beats]);
                     check("beat_last", out_last, (beats == L - 1));
                     beats++;
                  end
               end
            end
            pv = out_valid;
            pr = rdy;
            pd = out_data;
            pl = out_last;
            pa = rd_addr;
         end
      end

      check("run_terminated", fin, 1);
      if (!early) begin
         check("beat_count", beats, L);
         check("cap_en_cycles", cap_hi, ARM_CYCLES);
         check("cap_en_edges", cap_rise, 1);
         check("no_aborted_pulse", abort_cnt, 0);
         check("rd_addr_range", viol, 0);
         if (rmode == 0) begin
            check("done_latency", done_at, ARM_CYCLES + CAP_CYCLES + L + 2);
            check("first_valid", first_at, ARM_CYCLES + CAP_CYCLES + 2);
         end
         @(posedge clk);
         #1;
         check("done_one_cycle", done, 0);
         check("idle_after_done", busy, 0);
      end
      out_ready = 1'b0;
      cfg_len   = 9'd0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'd0;

      // Asynchronous reset state, before any clock edge
      #2;
      check("reset_outputs",
            {cap_en, rd_addr, out_data, out_valid, out_last, busy, done, aborted}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_reset", {busy, cap_en, done, aborted}, 0);

      // Basic readout of 8 samples
      run(9'd8, 0, -1, -1, -1, -1);
      // Zero and oversize lengths read the whole buffer
      run(9'd0, 0, -1, -1, -1, -1);
      run(9'd511, 0, -1, -1, -1, -1);
      run(9'd501, 2, -1, -1, -1, -1);
      // Toggling ready: stalls must hold the beat stable
      run(9'd4, 1, -1, -1, -1, -1);
      // Abort in WAIT, then abort after 3 of 8 beats; each followed by a normal run
      run(9'd8, 0, -1, ARM_CYCLES + 10, -1, -1);
      run(9'd8, 0, -1, -1, -1, -1);
      run(9'd8, 0, 3, -1, -1, -1);
      run(9'd8, 1, -1, -1, -1, -1);
      // Start pulsed during READ is ignored
      run(9'd6, 0, -1, -1, ARM_CYCLES + CAP_CYCLES + 4, -1);

      // Start together with abort in IDLE is ignored
      cfg_len = 9'd5;
      start   = 1'b1;
      abort   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("start_abort_idle_busy", busy, 0);
         check("start_abort_idle_cap_en", cap_en, 0);
         @(posedge clk);
         #1;
      end
      // Abort alone in IDLE has no effect
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("idle_abort_no_pulse", aborted, 0);

      // Reset mid-READ, then a normal run
      run(9'd8, 0, -1, -1, -1, ARM_CYCLES + CAP_CYCLES + 5);
      run(9'd3, 0, -1, -1, -1, -1);

      // Randomized lengths with random ready, including a one-sample readout
      run(9'd1, 2, -1, -1, -1, -1);
      for (int r = 0; r < 3; r++) begin
         run(9'($urandom_range(1, 48)), 2, -1, -1, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
